dct_mac_seq: RTL and testbench
==============================

// Module: dct_mac_seq
// PURPOSE
//   Sequencer and multiply-accumulate front end for one DCT unit in the fdct_zigzag path.
//   - Accepts TAPS signed sample/coefficient pairs over a valid/ready handshake.
//   - Accumulates their products, rounds and scales the sum, and presents one result word
//     to the downstream result register / zig-zag stage over a second valid/ready handshake.
// PARAMETERS
//   IW     8   input sample width (signed)
//   CW     12  coefficient width (signed)
//   OW     12  output result width (signed)
//   TAPS   8   products accumulated per result (>=2)
//   SHIFT  8   right-shift applied after rounding (>=1)
//   AW = IW+CW+$clog2(TAPS), internal accumulator width (localparam)
// PORTS
//   clk        in   1     clock, all state updates on rising edge
//   rst        in   1     asynchronous reset, active low
//   ena        in   1     global clock enable; low freezes all state and outputs
//   in_valid   in   1     din/coef valid
//   in_ready   out  1     block accepts a pair this cycle
//   din        in   IW    signed sample
//   coef       in   CW    signed coefficient paired with din
//   out_valid  out  1     dout valid
//   out_ready  in   1     downstream accepts dout
//   dout       out  OW    signed rounded result
//   ovf        out  1     result was saturated (only with DCT_MAC_SAT_EN)
// BEHAVIOUR
//   Reset (rst low, async): state=ACC, cnt=0, acc=0, prod stage empty, out_valid=0,
//     dout=0, ovf=0, in_ready=1 after release.
//   Accept: a pair is taken when ena & in_valid & in_ready.
//   States:
//     ACC   - in_ready=1; each accepted pair registers din*coef (full IW+CW product),
//             then adds it, sign-extended, into acc on the next ena cycle.
//             cnt increments per accept.
//             On the TAPS-th accept: cnt wraps to 0 and the state goes to FLUSH.
//     FLUSH - in_ready=0; the last product is added into acc; go to ROUND.
//     ROUND - in_ready=0; r = (acc + 2**(SHIFT-1)) >>> SHIFT (arithmetic shift).
//             r is converted to OW bits (see CONFIGURATION) into dout.
//             Then out_valid=1, acc cleared, go to OUT.
//     OUT   - in_ready=0; dout/out_valid/ovf are held stable until out_ready=1.
//             On out_ready=1: out_valid=0 and go to ACC (in_ready=1 the next cycle).
//   Latency: TAPS-th accept in cycle N -> out_valid=1 in cycle N+3 (ena held high).
//   Throughput: one result per TAPS+3 cycles minimum; in_valid gaps are allowed anywhere.
//   Rounding: round-half-up, e.g. -0.5 rounds to 0.
//   acc width AW never overflows for full-scale inputs.
//   ena low: no accept (in_ready is still driven), no state/counter/acc change,
//     outputs held unchanged.
//   Reset mid-block: partial acc and cnt are discarded; the next block starts clean.
//   out_ready while out_valid=0: ignored. in_valid while in_ready=0: ignored,
//     the upstream holds its data.
// CONFIGURATION
//   DCT_MAC_SAT_EN defined:
//     - r > 2**(OW-1)-1 gives dout = 2**(OW-1)-1 and ovf=1.
//     - r < -2**(OW-1) gives dout = -2**(OW-1) and ovf=1.
//     - otherwise dout=r[OW-1:0] and ovf=0.
//   DCT_MAC_SAT_EN undefined:
//     - dout=r[OW-1:0] (two's-complement wrap).
//     - ovf is tied to 0.
// TESTING (defaults; out_ready=1, ena=1 unless stated)
//   1. 8 pairs din=1, coef=256 -> acc=2048, dout=8, ovf=0; out_valid 3 cycles after 8th accept.
//   2. 8 pairs din=127, coef=2047 -> r=8124.
//      With SAT_EN: dout=2047, ovf=1. Without: dout=-68, ovf=0.
//   3. Rounding: one pair din=8, coef=16, seven pairs coef=0 -> dout=1.
//      Same block with din=-8 -> dout=0.
//   4. Backpressure: out_ready=0 for 5 cycles after out_valid -> dout and out_valid stable,
//      in_ready=0 throughout.
//      Then out_ready=1 -> in_ready=1 next cycle; next block accepted.
//   5. Reset mid-block: assert rst after 4 accepts -> out_valid=0, dout=0.
//      Then a full test-1 block -> dout=8 (no residue from the partial block).
//   6. ena low 3 cycles mid-block with in_valid=1 -> no accepts, cnt/acc unchanged.
//      The block completes later with the test-1 result (dout=8).

Source files
------------

// File: rtl/dct_mac_seq.sv
// DCT multiply-accumulate sequencer: TAPS signed products are summed, rounded half-up and scaled.
// Optional output saturation with ovf flag when DCT_MAC_SAT_EN is defined.
module dct_mac_seq #(
  parameter int IW    = 8,
  parameter int CW    = 12,
  parameter int OW    = 12,
  parameter int TAPS  = 8,
  parameter int SHIFT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [IW-1:0] din,
  input  logic signed [CW-1:0] coef,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] dout,
  output logic                 ovf
);
  localparam int AW   = IW + CW + $clog2(TAPS);
  localparam int PW   = IW + CW;
  localparam int CNTW = $clog2(TAPS);

  localparam logic [1:0] S_ACC   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic signed [AW:0] RND  = (AW+1)'(1) << (SHIFT-1);
  localparam logic signed [AW:0] MAXV = (AW+1)'(2**(OW-1)-1);
  localparam logic signed [AW:0] MINV = ~MAXV;

  logic [1:0]            state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [PW-1:0]  prod_q, prod_d;
  logic                  prod_vld_q, prod_vld_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [OW-1:0]  dout_q, dout_d;
  logic                  ovf_q, ovf_d;

  logic                  accept;
  logic signed [AW-1:0]  acc_in;
  logic signed [AW:0]    rsum, r;

  assign in_ready  = (state_q == S_ACC);
  assign accept    = ena & in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

  // Product stage drains into the accumulator one cycle after it was loaded.
  assign acc_in = prod_vld_q ? acc_q + {{(AW-PW){prod_q[PW-1]}}, prod_q} : acc_q;
  assign rsum   = $signed({acc_q[AW-1], acc_q}) + RND;
  assign r      = rsum >>> SHIFT;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    prod_vld_d  = prod_vld_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    if (ena) begin
      case (state_q)
        S_ACC: begin
          acc_d      = acc_in;
          prod_vld_d = accept;
          if (accept) begin
            prod_d = din * coef;
            if (cnt_q == CNTW'(TAPS-1)) begin
              cnt_d   = '0;
              state_d = S_FLUSH;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end
        end
        S_FLUSH: begin
          acc_d      = acc_in;
          prod_vld_d = 1'b0;
          state_d    = S_ROUND;
        end
        S_ROUND: begin
`ifdef DCT_MAC_SAT_EN
          if (r > MAXV) begin
            dout_d = OW'(MAXV);
            ovf_d  = 1'b1;
          end else if (r < MINV) begin
            dout_d = OW'(MINV);
            ovf_d  = 1'b1;
          end else begin
            dout_d = OW'(r);
            ovf_d  = 1'b0;
          end
`else
          dout_d = OW'(r);
          ovf_d  = 1'b0;
`endif
          out_valid_d = 1'b1;
          acc_d       = '0;
          state_d     = S_OUT;
        end
        default: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_ACC;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end
endmodule

// File: tb/tb_dct_mac_seq.sv
// Randomized self-checking bench for dct_mac_seq against a plain-arithmetic block model.
module tb_dct_mac_seq;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               ena = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  din = '0;
  logic signed [11:0] coef = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [11:0] dout;
  logic               ovf;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc;
  int blk_din[8];
  int blk_coef[8];

  dct_mac_seq dut (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .coef(coef), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sum of products, round half up by floor((s + 128) / 256), then saturate or wrap to 12 bits.
  task automatic model(output longint r_exp, output longint ovf_exp);
    longint s, t, q, w;
    s = 0;
    for (int i = 0; i < 8; i++) s += longint'(blk_din[i]) * longint'(blk_coef[i]);
    t = s + 128;
    q = (t >= 0) ? t / 256 : -((-t + 255) / 256);
`ifdef DCT_MAC_SAT_EN
    if (q > 2047) begin r_exp = 2047; ovf_exp = 1; end
    else if (q < -2048) begin r_exp = -2048; ovf_exp = 1; end
    else begin r_exp = q; ovf_exp = 0; end
`else
    w = ((q % 4096) + 4096) % 4096;
    if (w >= 2048) w -= 4096;
    r_exp = w;
    ovf_exp = 0;
`endif
  endtask

  task automatic set_const(input int d, input int c);
    for (int i = 0; i < 8; i++) begin blk_din[i] = d; blk_coef[i] = c; end
  endtask

  task automatic set_rand();
    logic signed [7:0]  d8;
    logic signed [11:0] c12;
    for (int i = 0; i < 8; i++) begin
      d8 = 8'($urandom);
      c12 = 12'($urandom);
      blk_din[i] = int'(d8);
      blk_coef[i] = int'(c12);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic push(input int d, input int c);
    int k;
    k = 0;
    din = 8'(d);
    coef = 12'(c);
    in_valid = 1'b1;
    while (!(in_ready && ena) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("push_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic wait_out(input string tag, input bit backp);
    int k;
    longint r_exp, o_exp;
    logic signed [11:0] held;
    k = 0;
    while (!out_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_out_valid"}, out_valid, 1);
    // out_valid is first seen two posedges after the accepting posedge (3 cycles after accept)
    chk({tag, "_latency"}, cyc - last_acc, 2);
    model(r_exp, o_exp);
    chk({tag, "_dout"}, dout, r_exp);
    chk({tag, "_ovf"}, ovf, o_exp);
    chk({tag, "_in_ready_out"}, in_ready, 0);
    if (backp) begin
      held = dout;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk({tag, "_bp_valid"}, out_valid, 1);
        chk({tag, "_bp_dout"}, dout, r_exp);
        chk({tag, "_bp_in_ready"}, in_ready, 0);
      end
      chk({tag, "_bp_held"}, dout, held);
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  task automatic run_block(input string tag, input bit gaps, input bit backp);
    if (backp) out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
      push(blk_din[i], blk_coef[i]);
    end
    wait_out(tag, backp);
  endtask

  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    set_const(1, 256);
    run_block("t1", 0, 0);
    set_const(127, 2047);
    run_block("t2", 0, 0);

    set_const(8, 0);
    blk_coef[0] = 16;
    run_block("t3_pos", 0, 0);
    blk_din[0] = -8;
    run_block("t3_neg", 0, 0);

    set_const(1, 256);
    run_block("t4_bp", 0, 1);
    set_const(-3, 700);
    run_block("t4_next", 1, 0);

    // Partial block then reset; the next block must carry no residue.
    set_const(50, 1000);
    for (int i = 0; i < 4; i++) push(blk_din[i], blk_coef[i]);
    rst = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_dout", dout, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_in_ready", in_ready, 1);
    set_const(1, 256);
    run_block("t5_after", 0, 0);

    // ena low mid-block with in_valid held: nothing may be accepted.
    set_const(1, 256);
    for (int i = 0; i < 3; i++) push(blk_din[i], blk_coef[i]);
    ena = 1'b0;
    in_valid = 1'b1;
    din = 8'(blk_din[3]);
    coef = 12'(blk_coef[3]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_in_ready", in_ready, 1);
      chk("t6_no_out", out_valid, 0);
    end
    ena = 1'b1;
    for (int i = 3; i < 8; i++) push(blk_din[i], blk_coef[i]);
    wait_out("t6", 0);

    set_const(-128, -2048);
    run_block("full_pos", 0, 0);
    set_const(-128, 2047);
    run_block("full_neg", 1, 0);

    for (int b = 0; b < 15; b++) begin
      set_rand();
      run_block("rand", 1, (b % 4) == 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
